// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions, trains a 2-bit BHT,
// and reports redirect, mispredict and flush along with resolve statistics.
module branch_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inBranch,
    input  logic              inStall,
    input  logic [2:0]        inCond,
    input  logic [DATA_W-1:0] inDataA,
    input  logic [DATA_W-1:0] inDataB,
    input  logic [IDX_W-1:0]  inResolveIdx,
    input  logic              inPredictedTaken,
    input  logic [IDX_W-1:0]  inPredictIdx,
    output logic              outPredictTaken,
    output logic              outPCSrc,
    output logic              outMispredict,
    output logic              outFlush,
    output logic [CNT_W-1:0]  outBranchCount,
    output logic [CNT_W-1:0]  outMispredictCount
);

    logic [1:0] bht [BHT_DEPTH];
    logic       taken;
    logic       reserved;
    logic       mispredict;
    logic       a_neg;
    logic       a_zero;
    logic [1:0] entry;
    logic [1:0] stepped;

    assign a_neg  = inDataA[DATA_W-1];
    assign a_zero = (inDataA == '0);

    always_comb begin
        taken    = 1'b0;
        reserved = 1'b0;
        case (inCond)
            3'b000:  taken = (inDataA == inDataB);
            3'b001:  taken = (inDataA != inDataB);
            3'b010:  taken = a_neg | a_zero;
            3'b011:  taken = ~a_neg & ~a_zero;
            3'b100:  taken = a_neg;
            3'b101:  taken = ~a_neg;
            default: reserved = 1'b1;
        endcase
    end

    assign mispredict = (taken != inPredictedTaken);

    // Saturating step of the 2-bit counter being resolved
    assign entry = bht[inResolveIdx];
    always_comb begin
        stepped = entry;
        if (taken) begin
            if (entry != 2'b11)
                stepped = entry + 2'd1;
        end else begin
            if (entry != 2'b00)
                stepped = entry - 2'd1;
        end
    end

    assign outPredictTaken = bht[inPredictIdx][1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outPCSrc           <= 1'b0;
            outMispredict      <= 1'b0;
            outFlush           <= 1'b0;
            outBranchCount     <= '0;
            outMispredictCount <= '0;
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= 2'b01;
        end else if (!inStall) begin
            outPCSrc      <= inBranch & taken;
            outMispredict <= inBranch & mispredict;
            outFlush      <= inBranch & mispredict;
            if (inBranch) begin
                if (outBranchCount != '1)
                    outBranchCount <= outBranchCount + CNT_W'(1);
                if (mispredict && outMispredictCount != '1)
                    outMispredictCount <= outMispredictCount + CNT_W'(1);
                if (!reserved)
                    bht[inResolveIdx] <= stepped;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        inBranch;
    logic        inStall;
    logic [2:0]  inCond;
    logic [31:0] inDataA;
    logic [31:0] inDataB;
    logic [3:0]  inResolveIdx;
    logic        inPredictedTaken;
    logic [3:0]  inPredictIdx;
    logic        outPredictTaken;
    logic        outPCSrc;
    logic        outMispredict;
    logic        outFlush;
    logic [15:0] outBranchCount;
    logic [15:0] outMispredictCount;

    int pass_cnt = 0;
    int total = 0;

    branch_resolve_unit dut (
        .clk                (clk),
        .reset              (reset),
        .inBranch           (inBranch),
        .inStall            (inStall),
        .inCond             (inCond),
        .inDataA            (inDataA),
        .inDataB            (inDataB),
        .inResolveIdx       (inResolveIdx),
        .inPredictedTaken   (inPredictedTaken),
        .inPredictIdx       (inPredictIdx),
        .outPredictTaken    (outPredictTaken),
        .outPCSrc           (outPCSrc),
        .outMispredict      (outMispredict),
        .outFlush           (outFlush),
        .outBranchCount     (outBranchCount),
        .outMispredictCount (outMispredictCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic any_taken;
        reset = 1'b0;
        inBranch = 1'b0;
        inStall = 1'b0;
        inCond = 3'b000;
        inDataA = '0;
        inDataB = '0;
        inResolveIdx = '0;
        inPredictedTaken = 1'b0;
        inPredictIdx = '0;
        tick();
        tick();
        total++;
        if ({outPCSrc, outMispredict, outFlush} !== 3'b000)
            $display("FAIL reset_flags got %b want 000",
                     {outPCSrc, outMispredict, outFlush});
        else pass_cnt++;
        total++;
        if ({outBranchCount, outMispredictCount} !== 32'h0)
            $display("FAIL reset_counts got %h/%h want 0/0",
                     outBranchCount, outMispredictCount);
        else pass_cnt++;
        any_taken = 1'b0;
        for (int i = 0; i < 16; i++) begin
            inPredictIdx = 4'(i);
            #1;
            any_taken |= outPredictTaken;
        end
        total++;
        if (any_taken !== 1'b0)
            $display("FAIL reset_predict got %b want 0", any_taken);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_beq();
        inBranch = 1'b1;
        inCond = 3'b000;
        inDataA = 32'h5;
        inDataB = 32'h5;
        inPredictedTaken = 1'b0;
        inResolveIdx = 4'd3;
        inPredictIdx = 4'd3;
        tick();
        total++;
        if ({outPCSrc, outMispredict, outFlush} !== 3'b111)
            $display("FAIL beq_flags got %b want 111",
                     {outPCSrc, outMispredict, outFlush});
        else pass_cnt++;
        total++;
        if (dut.bht[3] !== 2'b10)
            $display("FAIL beq_bht3 got %b want 10", dut.bht[3]);
        else pass_cnt++;
        total++;
        if (outPredictTaken !== 1'b1)
            $display("FAIL beq_predict got %b want 1", outPredictTaken);
        else pass_cnt++;
        total++;
        if (outBranchCount !== 16'd1 || outMispredictCount !== 16'd1)
            $display("FAIL beq_counts got %0d/%0d want 1/1",
                     outBranchCount, outMispredictCount);
        else pass_cnt++;
        inBranch = 1'b0;
        tick();
        total++;
        if ({outPCSrc, outMispredict, outFlush} !== 3'b000)
            $display("FAIL beq_pulse_clear got %b want 000",
                     {outPCSrc, outMispredict, outFlush});
        else pass_cnt++;
    endtask

    task automatic test_signed();
        inBranch = 1'b1;
        inResolveIdx = 4'd0;
        inCond = 3'b100;
        inDataA = 32'h8000_0000;
        inDataB = 32'h1234;
        inPredictedTaken = 1'b1;
        tick();
        total++;
        if (outPCSrc !== 1'b1 || outMispredict !== 1'b0)
            $display("FAIL bltz got pc=%b mp=%b want pc=1 mp=0",
                     outPCSrc, outMispredict);
        else pass_cnt++;
        inCond = 3'b101;
        inDataA = 32'h0;
        inPredictedTaken = 1'b0;
        tick();
        total++;
        if (outPCSrc !== 1'b1 || outMispredict !== 1'b1)
            $display("FAIL bgez_zero got pc=%b mp=%b want pc=1 mp=1",
                     outPCSrc, outMispredict);
        else pass_cnt++;
        inCond = 3'b011;
        tick();
        total++;
        if (outPCSrc !== 1'b0 || outMispredict !== 1'b0)
            $display("FAIL bgtz_zero got pc=%b mp=%b want pc=0 mp=0",
                     outPCSrc, outMispredict);
        else pass_cnt++;
        inCond = 3'b010;
        inDataA = 32'h0000_0001;
        tick();
        total++;
        if (outPCSrc !== 1'b0)
            $display("FAIL blez_pos got %b want 0", outPCSrc);
        else pass_cnt++;
        total++;
        if (outBranchCount !== 16'd5 || outMispredictCount !== 16'd2)
            $display("FAIL signed_counts got %0d/%0d want 5/2",
                     outBranchCount, outMispredictCount);
        else pass_cnt++;
    endtask

    task automatic test_bht_saturate();
        logic [1:0] want_bht [4];
        logic       want_pred [4];
        want_bht = '{2'b10, 2'b11, 2'b11, 2'b11};
        want_pred = '{1'b0, 1'b1, 1'b1, 1'b1};
        inBranch = 1'b1;
        inCond = 3'b001;
        inDataA = 32'h1;
        inDataB = 32'h2;
        inPredictedTaken = 1'b1;
        inResolveIdx = 4'd7;
        inPredictIdx = 4'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (outPredictTaken !== want_pred[i])
                $display("FAIL bht_predict%0d got %b want %b",
                         i, outPredictTaken, want_pred[i]);
            else pass_cnt++;
            tick();
            total++;
            if (dut.bht[7] !== want_bht[i])
                $display("FAIL bht_path%0d got %b want %b",
                         i, dut.bht[7], want_bht[i]);
            else pass_cnt++;
        end
        total++;
        if (outBranchCount !== 16'd9 || outMispredictCount !== 16'd2)
            $display("FAIL bht_counts got %0d/%0d want 9/2",
                     outBranchCount, outMispredictCount);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        inBranch = 1'b0;
        tick();
        inBranch = 1'b1;
        inStall = 1'b1;
        inCond = 3'b000;
        inDataA = 32'h5;
        inDataB = 32'h5;
        inPredictedTaken = 1'b0;
        inResolveIdx = 4'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({outPCSrc, outMispredict, outFlush} !== 3'b000 ||
                outBranchCount !== 16'd9 || outMispredictCount !== 16'd2 ||
                dut.bht[5] !== 2'b01)
                $display("FAIL stall_hold%0d got %b %0d/%0d bht=%b want 000 9/2 bht=01",
                         i, {outPCSrc, outMispredict, outFlush},
                         outBranchCount, outMispredictCount, dut.bht[5]);
            else pass_cnt++;
        end
        inStall = 1'b0;
        tick();
        total++;
        if ({outPCSrc, outMispredict, outFlush} !== 3'b111 ||
            outBranchCount !== 16'd10 || outMispredictCount !== 16'd3 ||
            dut.bht[5] !== 2'b10)
            $display("FAIL stall_release got %b %0d/%0d bht=%b want 111 10/3 bht=10",
                     {outPCSrc, outMispredict, outFlush},
                     outBranchCount, outMispredictCount, dut.bht[5]);
        else pass_cnt++;
        inBranch = 1'b0;
        inStall = 1'b1;
        tick();
        total++;
        if ({outPCSrc, outMispredict, outFlush} !== 3'b111)
            $display("FAIL stall_keeps_flags got %b want 111",
                     {outPCSrc, outMispredict, outFlush});
        else pass_cnt++;
        inStall = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        logic all_wn;
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (outFlush !== 1'b0 || outMispredict !== 1'b0)
            $display("FAIL async_reset got fl=%b mp=%b want 0 0",
                     outFlush, outMispredict);
        else pass_cnt++;
        all_wn = 1'b1;
        for (int i = 0; i < 16; i++)
            if (dut.bht[i] !== 2'b01) all_wn = 1'b0;
        total++;
        if (all_wn !== 1'b1 || outBranchCount !== 16'd0)
            $display("FAIL reset_bht_wn got wn=%b cnt=%0d want 1 0",
                     all_wn, outBranchCount);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        inBranch = 1'b1;
        inCond = 3'b110;
        inPredictedTaken = 1'b0;
        inResolveIdx = 4'd2;
        for (int i = 0; i < 65535; i++)
            tick();
        total++;
        if (outBranchCount !== 16'hFFFF || outMispredictCount !== 16'd0)
            $display("FAIL preload got %h/%h want ffff/0",
                     outBranchCount, outMispredictCount);
        else pass_cnt++;
        inPredictedTaken = 1'b1;
        tick();
        total++;
        if (outBranchCount !== 16'hFFFF)
            $display("FAIL count_saturate got %h want ffff", outBranchCount);
        else pass_cnt++;
        total++;
        if (outMispredict !== 1'b1 || outPCSrc !== 1'b0 ||
            outMispredictCount !== 16'd1)
            $display("FAIL reserved_mp got mp=%b pc=%b cnt=%0d want 1 0 1",
                     outMispredict, outPCSrc, outMispredictCount);
        else pass_cnt++;
        total++;
        if (dut.bht[2] !== 2'b01)
            $display("FAIL reserved_bht got %b want 01", dut.bht[2]);
        else pass_cnt++;
        inBranch = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed();
        test_bht_saturate();
        test_stall();
        test_reset_mid_pulse();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
